// File: rtl/result_reader.sv
// Captures datapath result words into a small circular buffer and drains them
// MSB-first as a byte stream over a valid/ready handshake; drops are flagged.
module result_reader #(
  parameter int DATA_W = 32,
  parameter int BYTE_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       we,
  input  logic [DATA_W-1:0]          wdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [BYTE_W-1:0]          out_data,
  output logic                       out_last
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int BEATS  = DATA_W / BYTE_W;
  localparam int BCNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [PTR_W-1:0]  PTR_ONE   = PTR_W'(1);
  localparam logic [BCNT_W-1:0] BCNT_ONE  = BCNT_W'(1);
  localparam logic [BCNT_W-1:0] LAST_BEAT = BCNT_W'(BEATS - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [DATA_W-1:0]   tx_sh;
  logic [BCNT_W-1:0]   bcnt;
  logic                push;
  logic                pop;
  logic                hs;

  assign full  = (count == CNT_FULL);
  assign empty = (count == '0);
  assign hs    = out_valid & out_ready;
  // A write against a full buffer is dropped even if a pop frees a slot this edge.
  assign push  = we & ~full;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // NOTE: every combinational output gets a default first, so no path through
  // the case leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = SEND;
        end
      end
      SEND: begin
        if (hs && out_last) begin
          if (!empty) pop     = 1'b1;
          else        state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    out_valid = 1'b0;
    out_data  = '0;
    out_last  = 1'b0;
    if (state_q == SEND) begin
      out_valid = 1'b1;
      out_data  = tx_sh[DATA_W-1 -: BYTE_W];
      out_last  = (bcnt == LAST_BEAT);
    end
  end

  // NOTE: the storage array has no reset; occupancy and pointers define which
  // entries are meaningful, so clearing the array would only cost area.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
      if (we && full) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_sh <= '0;
      bcnt  <= '0;
    end else if (pop) begin
      tx_sh <= mem[rd_ptr];
      bcnt  <= '0;
    end else if (hs && !out_last) begin
      tx_sh <= tx_sh << BYTE_W;
      bcnt  <= bcnt + BCNT_ONE;
    end
  end

endmodule

// File: doc/result_reader.md
# result_reader

Read-side companion to the approximate-multiplier datapath. It captures each 32-bit result the datapath writes on its write-enable strobe into a small circular buffer. It then drains the buffer as a byte stream, MSB first, over a valid/ready handshake to the downstream consumer. It decouples the datapath's write timing from the consumer's read rate and flags any result that is lost.

## Interface
Parameters:
- DATA_W, 32, result word width; must be a multiple of BYTE_W
- BYTE_W, 8, output beat width
- DEPTH, 4, buffer entries; power of two, ≥2

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- we  in  1  datapath write strobe; one word per asserted cycle
- wdata  in  DATA_W  result word, sampled when we=1
- full  out  1  count==DEPTH
- empty  out  1  count==0
- count  out  $clog2(DEPTH+1)  words held in buffer (excludes word in transmit register)
- overflow  out  1  sticky; set when a write is dropped
- out_valid  out  1  out_data holds a valid byte
- out_ready  in  1  consumer accepts byte when out_valid&&out_ready
- out_data  out  BYTE_W  current byte
- out_last  out  1  high on final byte of a word

## Operation
- Buffer: circular, write pointer wr_ptr, read pointer rd_ptr, occupancy count; pointers wrap modulo DEPTH.
- Write: we=1 and full=0 stores wdata at wr_ptr, wr_ptr+1. If we=1 while full=1, the word is dropped and overflow is set. This applies even if a pop occurs in the same cycle.
- Simultaneous push and pop (full=0): count unchanged, both pointers advance.
- Transmit register tx_sh (DATA_W), byte counter bcnt (0..DATA_W/BYTE_W-1).
- FSM states:
  - IDLE: out_valid=0. If empty=0, pop the head into tx_sh, set bcnt=0, and go to SEND.
  - SEND: out_valid=1, out_data=tx_sh[DATA_W-1 -: BYTE_W], out_last=(bcnt==DATA_W/BYTE_W-1).
    - On handshake with out_last=0: shift tx_sh left by BYTE_W and increment bcnt.
    - On handshake with out_last=1: if empty=0, pop the next word into tx_sh, set bcnt=0, and stay in SEND (no bubble). Otherwise go to IDLE.
    - Without a handshake: hold out_data, out_last and all state.
- out_valid, once raised, stays high until the handshake; out_data must not change while it is waiting.
- Byte order is MSB first: 0xAABBCCDD is sent as AA, BB, CC, DD.

## Timing
- Reset (rst=0, asynchronous) sets:
  - FSM to IDLE, pointers and count to 0, bcnt to 0, tx_sh to 0, overflow to 0.
  - Outputs: out_valid=0, out_data=0, out_last=0, empty=1, full=0.
- Reset mid-word: the partial word and all buffered words are discarded. No further bytes are emitted after rst releases until a new write arrives.
- Latency: we in cycle N with the FSM in IDLE and empty=1 means the word is stored at edge N, popped at edge N+1, and out_valid is high in cycle N+2.
- Throughput: one byte per cycle with out_ready held high. Back-to-back words are emitted with no idle cycle between the out_last byte and the next word's first byte.
- full, empty and count are registered-state decodes; they reflect the edge just taken.
- Pop and push in the same edge while count==DEPTH-1: count is unchanged and full stays 0.

## Test plan
- Reset check: assert rst=0 mid-run -> out_valid=0, out_data=0, out_last=0, empty=1, full=0, count=0, overflow=0 immediately, without waiting for a clock edge.
- Single word: we with 0x12345678, out_ready=1 -> out_valid rises 2 cycles later. Bytes 12, 34, 56, 78 on consecutive cycles; out_last only on 78; then IDLE and empty=1.
- Backpressure: same word with out_ready toggling 1,0,0,1,… -> each byte holds stable while out_ready=0. The sequence is still 12, 34, 56, 78 with no repeats or drops.
- Back-to-back words: write 0xA1A2A3A4 and 0xB1B2B3B4 on consecutive cycles, out_ready=1 -> 8 bytes on 8 consecutive cycles, with out_last on A4 and B4.
- Overflow: out_ready=0, write 5 words 0x1..0x5 -> first word in tx_sh and 4 buffered. A 6th write sets overflow=1 and full stays 1. Draining yields words 1..5 only, and overflow stays 1 until reset.
- Reset mid-word: after bytes 12, 34 of 0x12345678 are sent, pulse rst=0 -> no further bytes. A new write of 0xCAFEBABE then yields CA, FE, BA, BE.
